// File: rtl/reglist_seq_encoder.sv
// Sequential priority encoder for LDM/STM register lists: emits one register index per accepted
// transfer. Define REGLIST_DESC_EN to emit highest register first instead of lowest.
module reglist_seq_encoder #(
   parameter int LIST_W = 16,
   parameter int IDX_W  = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LIST_W-1:0] reg_list,
   input  logic              advance,
   output logic [IDX_W-1:0]  idx,
   output logic              valid,
   output logic              last,
   output logic              busy,
   output logic              done,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [LIST_W-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty_q, empty_d;

   logic [IDX_W-1:0]  sel_idx;
   logic [CNT_W-1:0]  list_cnt;
   logic              single;

   // Later loop iterations win, so the scan runs away from the preferred end.
   always_comb begin
      sel_idx = '0;
`ifdef REGLIST_DESC_EN
      for (int i = 0; i < LIST_W; i++) begin
         if (pending_q[i]) sel_idx = IDX_W'(i);
      end
`else
      for (int i = LIST_W - 1; i >= 0; i--) begin
         if (pending_q[i]) sel_idx = IDX_W'(i);
      end
`endif
   end

   always_comb begin
      list_cnt = '0;
      for (int i = 0; i < LIST_W; i++) begin
         list_cnt = list_cnt + CNT_W'(reg_list[i]);
      end
   end

   assign single = (pending_q != '0) && ((pending_q & (pending_q - LIST_W'(1))) == '0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      empty_d   = empty_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               pending_d = reg_list;
               count_d   = list_cnt;
               empty_d   = (reg_list == '0);
               state_d   = (reg_list == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (advance) begin
               pending_d = pending_q & ~(LIST_W'(1) << sel_idx);
               if (single) state_d = FIN;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         count_q   <= '0;
         empty_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
      end
   end

   always_comb begin
      valid = (state_q == RUN);
      idx   = valid ? sel_idx : '0;
      last  = valid && single;
      busy  = (state_q != IDLE);
      done  = (state_q == FIN);
      empty = done && empty_q;
      count = count_q;
   end

endmodule

// File: tb/tb_reglist_seq_encoder.sv
// Scoreboard bench for reglist_seq_encoder: a set-bit-list model feeds an expectation queue that
// a negedge monitor drains as the DUT presents indices and done pulses.
module tb_reglist_seq_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] reg_list = '0;
   logic        advance = 1'b0;
   logic [3:0]  idx;
   logic        valid, last, busy, done, empty;
   logic [4:0]  count;

   reglist_seq_encoder dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .reg_list (reg_list),
      .advance  (advance),
      .idx      (idx),
      .valid    (valid),
      .last     (last),
      .busy     (busy),
      .done     (done),
      .empty    (empty),
      .count    (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit   fin;
      int   idx;
      bit   last;
      int   cnt;
      bit   emp;
      int   dcyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=no_event (cycle %0d)", name, cyc);
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (!valid) begin
               check("idx_zero_when_invalid", int'(idx), 0);
               check("last_zero_when_invalid", int'(last), 0);
            end else if (sb.size() == 0 || sb[0].fin) begin
               fail("unexpected_valid");
            end else begin
               check("idx", int'(idx), sb[0].idx);
               check("last", int'(last), int'(sb[0].last));
               check("count_run", int'(count), sb[0].cnt);
               check("busy_run", int'(busy), 1);
               if (advance) void'(sb.pop_front());
            end
            if (done) begin
               if (sb.size() == 0 || !sb[0].fin) begin
                  fail("unexpected_done");
               end else begin
                  check("empty", int'(empty), int'(sb[0].emp));
                  check("count_done", int'(count), sb[0].cnt);
                  check("busy_fin", int'(busy), 1);
                  if (sb[0].dcyc >= 0) check("done_latency", cyc, sb[0].dcyc);
                  void'(sb.pop_front());
               end
            end else if (empty) begin
               fail("empty_without_done");
            end
         end
      end
   end

   // Reference: list of set registers in emission order.
   task automatic push_model(input logic [15:0] lst);
      int   order[$];
      exp_t e;
      for (int k = 0; k < 16; k++) if (lst[k]) order.push_back(k);
`ifdef REGLIST_DESC_EN
      order.reverse();
`endif
      foreach (order[j]) begin
         e = '{fin: 1'b0, idx: order[j], last: (j == order.size() - 1), cnt: order.size(),
               emp: 1'b0, dcyc: -1};
         sb.push_back(e);
      end
      e = '{fin: 1'b1, idx: 0, last: 1'b0, cnt: order.size(), emp: (order.size() == 0),
            dcyc: -1};
      sb.push_back(e);
   endtask

   // Waits for the scoreboard to drain, firing ignored starts while the DUT is busy.
   task automatic wait_idle(input int adv_pct);
      int n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) break;
         advance  = ($urandom_range(99) < adv_pct);
         start    = ($urandom_range(3) == 0);
         reg_list = 16'($urandom);
         n++;
         if (n > 400) begin
            fail("drain_timeout");
            sb.delete();
         end
      end
      start   = 1'b0;
      advance = 1'b0;
   endtask

   task automatic issue(input logic [15:0] lst, input int adv_pct);
      int n = $countones(lst);
      push_model(lst);
      start    = 1'b1;
      reg_list = lst;
      advance  = ($urandom_range(99) < adv_pct);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (adv_pct >= 100) sb[$].dcyc = cyc + n;
   endtask

   initial begin
      logic [15:0] lst;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_idx", int'(idx), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_last", int'(last), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_empty", int'(empty), 0);
      check("rst_count", int'(count), 0);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      issue(16'h8421, 100);
      wait_idle(100);
      issue(16'h0000, 100);
      wait_idle(100);
      check("idle_after_empty", int'(busy), 0);
      issue(16'h0006, 25);
      wait_idle(25);
      issue(16'hFFFF, 100);
      wait_idle(100);
      issue(16'h0001, 100);
      wait_idle(100);
      issue(16'h8000, 60);
      wait_idle(60);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(3))
            0: lst = 16'h1 << $urandom_range(15);
            1: lst = (t % 7 == 0) ? 16'h0 : 16'(~(16'h1 << $urandom_range(15)));
            default: lst = 16'($urandom);
         endcase
         issue(lst, (t % 3 == 0) ? 100 : 50);
         wait_idle((t % 3 == 0) ? 100 : 50);
      end

      // Abort a full-list sequence once index 7 is on the output.
      issue(16'hFFFF, 100);
      for (int n = 0; n < 40 && sb.size() > 10; n++) begin
         @(posedge clk);
         #1;
         advance = 1'b1;
      end
      check("abort_reached_idx7", sb.size(), 10);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      advance = 1'b0;
      sb.delete();
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_valid", int'(valid), 0);
      check("abort_count", int'(count), 0);
      repeat (20) @(posedge clk);
      #1;
      issue(16'h0A0A, 100);
      wait_idle(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
